// File: rtl/fb_read_arbiter.sv
// Two-port framebuffer read arbiter: scanout (port 0) has priority, CPU/blitter
// (port 1) is protected from starvation; responses are routed by an in-order ID FIFO.
module fb_read_arbiter #(
  parameter int MAX_PENDING  = 8,
  parameter int STARVE_LIMIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s0_read,
  input  logic [23:0] s0_address,
  output logic        s0_waitrequest,
  output logic [7:0]  s0_readdata,
  output logic        s0_readdatavalid,
  input  logic        s1_read,
  input  logic [23:0] s1_address,
  output logic        s1_waitrequest,
  output logic [7:0]  s1_readdata,
  output logic        s1_readdatavalid,
  output logic        m_read,
  output logic [23:0] m_address,
  input  logic        m_waitrequest,
  input  logic [7:0]  m_readdata,
  input  logic        m_readdatavalid,
  output logic        err_orphan
);
  localparam int PW = $clog2(MAX_PENDING + 1);
  localparam int AW = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e               state_q, state_d;
  logic                 lock_q, lock_d;
  logic [SW-1:0]        starve_q, starve_d;
  logic [PW-1:0]        pending_q, pending_d;
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [MAX_PENDING-1:0] fifo_q;
  logic [7:0]           rd0_q, rd1_q;
  logic                 rv0_q, rv1_q, orphan_q;

  logic sel, sel_read, full, accept, push, pop, head;

  always_comb begin
    if (state_q == LOCKED)
      sel = lock_q;
    else if (s0_read && !(s1_read && starve_q == SW'(STARVE_LIMIT)))
      sel = 1'b0;
    else
      sel = 1'b1;
  end

  assign sel_read  = sel ? s1_read : s0_read;
  assign full      = (pending_q == PW'(MAX_PENDING));
  // Reset gate keeps the master quiet while the rest of the logic is being cleared.
  assign m_read    = sel_read & ~full & ~reset;
  assign m_address = sel ? s1_address : s0_address;
  assign accept    = m_read & ~m_waitrequest;

  assign s0_waitrequest = s0_read & ~(accept & ~sel);
  assign s1_waitrequest = s1_read & ~(accept &  sel);

  assign push = accept;
  assign pop  = m_readdatavalid && (pending_q != '0);
  assign head = fifo_q[rd_ptr_q];

  always_comb begin
    state_d = IDLE;
    lock_d  = lock_q;
    if (m_read && m_waitrequest) begin
      state_d = LOCKED;
      lock_d  = sel;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!s1_read || (accept && sel))
      starve_d = '0;
    else if (accept && !sel && starve_q != SW'(STARVE_LIMIT))
      starve_d = starve_q + 1'b1;
  end

  always_comb begin
    pending_d = pending_q;
    case ({push, pop})
      2'b10:   pending_d = pending_q + 1'b1;
      2'b01:   pending_d = pending_q - 1'b1;
      default: pending_d = pending_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      lock_q    <= 1'b0;
      starve_q  <= '0;
      pending_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fifo_q    <= '0;
      rd0_q     <= '0;
      rd1_q     <= '0;
      rv0_q     <= 1'b0;
      rv1_q     <= 1'b0;
      orphan_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      lock_q    <= lock_d;
      starve_q  <= starve_d;
      pending_q <= pending_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= sel;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      rv0_q <= pop & ~head;
      rv1_q <= pop &  head;
      if (pop && !head) rd0_q <= m_readdata;
      if (pop &&  head) rd1_q <= m_readdata;
      if (m_readdatavalid && pending_q == '0) orphan_q <= 1'b1;
    end
  end

  assign s0_readdata      = rd0_q;
  assign s1_readdata      = rd1_q;
  assign s0_readdatavalid = rv0_q;
  assign s1_readdatavalid = rv1_q;
  assign err_orphan       = orphan_q;
endmodule

// File: tb/tb_fb_read_arbiter.sv
// Directed bench for fb_read_arbiter with a latency-3 memory responder driven per cycle.
module tb_fb_read_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        s0_read, s1_read;
  logic [23:0] s0_address, s1_address;
  logic        s0_waitrequest, s1_waitrequest;
  logic [7:0]  s0_readdata, s1_readdata;
  logic        s0_readdatavalid, s1_readdatavalid;
  logic        m_read;
  logic [23:0] m_address;
  logic        m_waitrequest;
  logic [7:0]  m_readdata;
  logic        m_readdatavalid;
  logic        err_orphan;

  int total = 0;
  int bad   = 0;

  logic       mem_en;
  logic [2:0] pv;
  logic [7:0] pd [3];
  logic       acc_log [$];

  always #5 clk = ~clk;

  fb_read_arbiter dut (
    .clk(clk), .reset(reset),
    .s0_read(s0_read), .s0_address(s0_address), .s0_waitrequest(s0_waitrequest),
    .s0_readdata(s0_readdata), .s0_readdatavalid(s0_readdatavalid),
    .s1_read(s1_read), .s1_address(s1_address), .s1_waitrequest(s1_waitrequest),
    .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
    .m_read(m_read), .m_address(m_address), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .err_orphan(err_orphan)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; the memory model records this cycle's accept and
  // presents its data three cycles later.
  task automatic tick();
    logic       a;
    logic [7:0] ad;
    a  = m_read && !m_waitrequest;
    ad = m_address[7:0];
    if (a) acc_log.push_back(m_address[23]);
    @(posedge clk);
    @(negedge clk);
    pv    = {pv[1:0], a && mem_en};
    pd[2] = pd[1]; pd[1] = pd[0]; pd[0] = ad;
    if (mem_en) begin
      m_readdatavalid = pv[2];
      m_readdata      = pd[2];
    end
    #1;
  endtask

  initial begin
    logic [63:0] got;
    reset = 1'b1; s0_read = 0; s1_read = 0; s0_address = '0; s1_address = '0;
    m_waitrequest = 0; m_readdata = '0; m_readdatavalid = 0;
    mem_en = 0; pv = '0; pd[0] = '0; pd[1] = '0; pd[2] = '0;
    @(negedge clk); #1;

    // Reset state
    s0_read = 1; s0_address = 24'h000011;
    tick(); tick();
    chk("rst_mread", m_read, 0);
    chk("rst_s0wr", s0_waitrequest, 1);
    chk("rst_s1wr", s1_waitrequest, 0);
    chk("rst_rv", {s0_readdatavalid, s1_readdatavalid}, 0);
    chk("rst_rd", {s0_readdata, s1_readdata}, 0);
    chk("rst_err", err_orphan, 0);
    reset = 0; s0_read = 0; tick();

    // Simultaneous reads, latency-3 memory
    mem_en = 1;
    s0_read = 1; s0_address = 24'h000011; s1_read = 1; s1_address = 24'h800022; #1;
    chk("sim_addr0", m_address, 24'h000011);
    chk("sim_wr", {s0_waitrequest, s1_waitrequest}, 2'b01);
    tick(); s0_read = 0; #1;
    chk("sim_addr1", m_address, 24'h800022);
    chk("sim_s1wr", s1_waitrequest, 0);
    tick(); s1_read = 0; #1;
    tick();
    chk("sim_rv_early", {s0_readdatavalid, s1_readdatavalid}, 0);
    tick();
    chk("sim_rv0", {s0_readdatavalid, s1_readdatavalid}, 2'b10);
    chk("sim_rd0", s0_readdata, 8'h11);
    tick();
    chk("sim_rv1", {s0_readdatavalid, s1_readdatavalid}, 2'b01);
    chk("sim_rd1", s1_readdata, 8'h22);
    tick();
    chk("sim_hold", {s1_readdatavalid, s1_readdata}, {1'b0, 8'h22});

    // Lock held across waitrequest
    m_waitrequest = 1; s1_read = 1; s1_address = 24'h800033; #1;
    chk("lock_c1", {m_address, s1_waitrequest}, {24'h800033, 1'b1});
    tick(); s0_read = 1; s0_address = 24'h000044; #1;
    for (int i = 0; i < 3; i++) begin
      chk("lock_addr", m_address, 24'h800033);
      chk("lock_s0wr", s0_waitrequest, 1);
      tick();
    end
    m_waitrequest = 0; #1;
    chk("lock_acc", {m_address, s1_waitrequest, s0_waitrequest}, {24'h800033, 2'b01});
    tick(); s1_read = 0; #1;
    chk("lock_next", {m_address, s0_waitrequest}, {24'h000044, 1'b0});
    tick(); s0_read = 0; #1;
    repeat (6) tick();

    // Starvation guard
    acc_log.delete();
    s0_read = 1; s0_address = 24'h000001; s1_read = 1; s1_address = 24'h800002; #1;
    repeat (34) tick();
    s0_read = 0; s1_read = 0; #1;
    chk("stv_cnt", acc_log.size(), 34);
    got = '0;
    for (int i = 0; i < acc_log.size() && i < 64; i++) got[i] = acc_log[i];
    chk("stv_pat", got, (64'd1 << 16) | (64'd1 << 33));
    repeat (6) tick();
    chk("stv_err", err_orphan, 0);

    // Pending full
    mem_en = 0; m_readdatavalid = 0; s0_read = 1; s0_address = 24'h000055; #1;
    repeat (8) tick();
    chk("full_mread", {m_read, s0_waitrequest}, 2'b01);
    tick();
    m_readdatavalid = 1; m_readdata = 8'h5A; #1;
    chk("full_pop_cyc", m_read, 0);
    tick();
    m_readdatavalid = 0; #1;
    chk("full_resume", {m_read, s0_waitrequest}, 2'b10);
    chk("full_rv", {s0_readdatavalid, s0_readdata}, {1'b1, 8'h5A});
    tick(); s0_read = 0; #1;
    for (int i = 0; i < 8; i++) begin
      m_readdatavalid = 1; m_readdata = 8'(i);
      tick();
    end
    m_readdatavalid = 0; #1;
    chk("full_last", {s0_readdatavalid, s0_readdata}, {1'b1, 8'h07});
    tick();
    chk("full_err", {err_orphan, s0_readdatavalid}, 2'b00);

    // Orphan data
    m_readdatavalid = 1; m_readdata = 8'hA5; tick();
    m_readdatavalid = 0; #1;
    chk("orph_rv", {s0_readdatavalid, s1_readdatavalid}, 0);
    chk("orph_err", err_orphan, 1);
    chk("orph_hold", s0_readdata, 8'h07);
    tick(); tick();
    chk("orph_sticky", err_orphan, 1);

    // Reset with reads pending
    reset = 1; tick(); reset = 0; #1;
    chk("r2_clr", {err_orphan, s0_readdata}, 0);
    s1_read = 1; s1_address = 24'h800077; tick(); tick(); tick();
    s1_read = 0; #1;
    reset = 1; tick(); reset = 0; #1;
    chk("r2_err0", err_orphan, 0);
    for (int i = 0; i < 3; i++) begin
      m_readdatavalid = 1; m_readdata = 8'(8'h10 + i);
      tick();
      chk("r2_norv", {s0_readdatavalid, s1_readdatavalid}, 0);
    end
    m_readdatavalid = 0; tick();
    chk("r2_err1", {err_orphan, s1_readdatavalid}, 2'b10);
    mem_en = 1; s1_read = 1; s1_address = 24'h8000C3; #1;
    tick(); s1_read = 0; #1;
    tick(); tick(); tick();
    chk("r2_new", {s1_readdatavalid, s1_readdata, err_orphan}, {1'b1, 8'hC3, 1'b1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
